// File: rtl/prng_pkg.sv
// Shared constants and types for the PRNG sharing controller.
package prng_pkg;

  // Width of one PRNG sample.
  localparam int DATA_W = 16;

  // Seed that game code drives on seed_in after power-up unless it chooses another.
  localparam logic [DATA_W-1:0] DEFAULT_SEED = 16'hA16F;

  // Controller phases: apply seed, discard warm-up samples, then share samples.
  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/prng_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  int               pos;
  logic [PTR_W-1:0] sel;

  // Scan N_REQ candidates starting at rr_ptr; the first asserted one wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    sel    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(rr_ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      sel = PTR_W'(pos);
      if (!found && req[sel]) begin
        found       = 1'b1;
        winner[sel] = 1'b1;
        idx         = sel;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Owns the game's single PRNG: seeds it, discards a warm-up run, then hands
// out one sample per cycle round-robin so no two consumers share a sample.
//
// Handshake: each consumer raises req[i] and holds it level until it sees
// gnt[i]. gnt is a one-cycle pulse and rnd_data carries the sample in that
// same cycle. A req still high at the edge where gnt is seen is treated as a
// new request, so dropping req on that cycle yields exactly one sample.
module prng_arbiter import prng_pkg::*; #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = prng_pkg::DATA_W,
  parameter int SEED_HOLD = 2,
  parameter int WARMUP    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] seed_in,
  input  logic              reseed,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [DATA_W-1:0] rnd_data,
  output logic              ready,
  output logic              prng_rstn,
  output logic [DATA_W-1:0] prng_seed,
  input  logic [DATA_W-1:0] prng_data
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(SEED_HOLD + 1);
  localparam int WARM_W = $clog2(WARMUP + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SEED_HOLD - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WARM_W-1:0] warm_cnt;
  logic              seed_armed;
  logic [DATA_W-1:0] seed_q;
  logic [PTR_W-1:0]  rr_ptr;
  logic              arb_en;

  logic [N_REQ-1:0]  win_onehot;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (win_onehot),
    .idx    (win_idx),
    .found  (win_found)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_SEED;
    else     state <= state_nxt;
  end

  // Next state: a reseed pulse always returns to SEED; otherwise advance
  // when the hold / warm-up counters reach their last cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEED: begin
        if (!reseed && hold_cnt == HOLD_LAST) state_nxt = ST_WARM;
      end
      ST_WARM: begin
        if (reseed)                      state_nxt = ST_SEED;
        else if (warm_cnt == WARM_LAST)  state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (reseed) state_nxt = ST_SEED;
      end
      default: state_nxt = ST_SEED;
    endcase
  end

  // Outputs decoded from the phase; prng is held in reset only while seeding.
  always_comb begin
    ready     = (state == ST_RUN);
    prng_rstn = (state != ST_SEED);
    arb_en    = (state == ST_RUN);
  end

  assign prng_seed = seed_q;

  // Seed latch and phase counters. After rst the seed is taken on the first
  // edge; after a reseed pulse it is taken on the entry edge itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt   <= '0;
      warm_cnt   <= '0;
      seed_q     <= '0;
      seed_armed <= 1'b1;
    end else if (reseed) begin
      hold_cnt   <= '0;
      warm_cnt   <= '0;
      seed_q     <= seed_in;
      seed_armed <= 1'b0;
    end else begin
      case (state)
        ST_SEED: begin
          if (seed_armed) begin
            seed_q     <= seed_in;
            seed_armed <= 1'b0;
          end
          hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
          warm_cnt <= '0;
        end
        ST_WARM: begin
          warm_cnt <= (warm_cnt == WARM_LAST) ? '0 : warm_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Grant register: one winner per RUN cycle, sample captured alongside; a
  // reseed in the same cycle cancels the grant and leaves rr_ptr untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      rnd_data <= '0;
      rr_ptr   <= '0;
    end else if (arb_en && !reseed && win_found) begin
      gnt      <= win_onehot;
      rnd_data <= prng_data;
      rr_ptr   <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
    end else begin
      gnt <= '0;
    end
  end

endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
- Controller that owns the single free-running 16-bit PRNG of the 2D game and shares its output stream among N_REQ consumers, for example the spawn, colour and motion logic.
- Sequences PRNG seeding and reset, discards a warm-up run of samples, then grants one sample per cycle round-robin, so no two consumers ever receive the same sample.
- Sits between the prng instance and the game logic. Supports run-time reseeding.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, PRNG sample width.
- SEED_HOLD, 2, cycles prng_rstn is held low while the seed is applied (>=1).
- WARMUP, 16, PRNG samples discarded after each seeding (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- seed_in  in  DATA_W  seed value; sampled on the cycle of entry into SEED.
- reseed  in  1  single-cycle pulse requesting reseed from seed_in.
- req  in  N_REQ  level request per consumer; held until granted.
- gnt  out  N_REQ  one-hot grant pulse; rnd_data is valid in the same cycle.
- rnd_data  out  DATA_W  granted sample.
- ready  out  1  high only in RUN.
- prng_rstn  out  1  active-low reset to the prng instance.
- prng_seed  out  DATA_W  seed driven to the prng instance.
- prng_data  in  DATA_W  current prng output; the prng advances every clk.

Behaviour:
- Reset values:
  - gnt=0, rnd_data=0, ready=0, prng_rstn=0, prng_seed=0.
  - State=SEED, rr pointer=0, counters=0.
- FSM states SEED, WARM, RUN:
  - SEED: prng_rstn=0, prng_seed=latched seed (captured from seed_in on entry; after rst, captured on the first clk edge). Stays SEED_HOLD cycles, then goes to WARM.
  - WARM: prng_rstn=1. Counts WARMUP cycles with no grants, then goes to RUN.
  - RUN: ready=1. Arbitration is active.
  - A reseed pulse in WARM or RUN goes to SEED on the next edge, restarts the hold counter and drops ready.
  - A reseed pulse in SEED restarts the hold count and relatches seed_in.
- Arbitration (RUN only):
  - On each cycle t where req is nonzero, select the first asserted bit at or after rr_ptr, wrapping modulo N_REQ.
  - At t+1, drive gnt[w]=1 and rnd_data=prng_data as sampled at t.
  - Set rr_ptr=(w+1) mod N_REQ.
  - At most one grant per cycle. A requester holding req continuously is granted at most once per N_REQ grants while others are requesting.
  - A single sole requester holding req is granted every cycle and receives consecutive PRNG samples.
  - The requester must drop req on the cycle it sees gnt if it wants only one sample. A request still high at that edge is re-arbitrated, so no sample is duplicated.
- rnd_data holds its last value when gnt=0. gnt is never asserted outside RUN.
- Requests during SEED/WARM are held pending, not dropped. They are arbitrated from the first RUN cycle; first grant arrives the cycle after.
- Reseed in the same cycle as a pending arbitration: the grant for that cycle is suppressed (gnt=0 at t+1).
- rst mid-operation clears everything asynchronously, including an in-flight grant.
- req bits for index >= N_REQ do not exist. rr_ptr wraps from N_REQ-1 to 0.

Decomposition:
- Shared package prng_pkg:
  - DATA_W.
  - State encoding constants ST_SEED, ST_WARM, ST_RUN.
  - Default seed 16'hA16F.
- One sub-module, rr_arbiter: combinational round-robin select. Inputs req, rr_ptr. Outputs one-hot winner and index.
- The FSM, counters and registers stay in prng_arbiter.

Test Plan:
Bench replaces the prng with a stub: prng_data = free-running 16-bit counter, reset to 0 by prng_rstn low.
1. Reset and seeding: rst released, seed_in=16'hA16F.
   - prng_rstn low exactly 2 cycles, prng_seed=16'hA16F.
   - ready rises after 16 further cycles.
   - No gnt before ready.
2. Single request: in RUN, req=4'b0010 for one cycle when stub=0x0025.
   - Next cycle gnt=4'b0010, rnd_data=0x0025.
   - Then gnt=0 and rnd_data holds.
3. Round-robin: req=4'b1111 held for 8 cycles.
   - gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
   - rnd_data strictly increments by 1 each grant.
4. Pending during warm-up: req=4'b0100 asserted in WARM.
   - Held; gnt=4'b0100 on the second RUN cycle.
   - rnd_data = stub value of the first RUN cycle (0x0010).
5. Reseed mid-stream: req=4'b1111 held, pulse reseed with seed_in=16'h1234.
   - gnt=0 the next cycle; prng_seed=16'h1234; prng_rstn low 2 cycles.
   - ready low for 18 cycles; grants resume at the rr_ptr saved before reseed.
6. Async reset mid-grant: assert rst between edges while gnt is high.
   - gnt, rnd_data, ready, prng_rstn go to 0 immediately, without waiting for a clk edge.
